// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: bundle between two RAM clients, the arbiter and the 16x4 async RAM.
//   Client side : reqA/B, weA/B, addrA/B, wdataA/B in; gntA/B, doneA/B, rdata, busy out.
//   RAM side    : ram_addr, ram_dataIN, ram_WR, ram_RD out; ram_dataOUT in.
// Modports: slave = arbiter view, master = client/RAM-environment view.
interface ram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
);
  logic              reqA, reqB;
  logic              weA, weB;
  logic [ADDR_W-1:0] addrA, addrB;
  logic [DATA_W-1:0] wdataA, wdataB;
  logic              gntA, gntB;
  logic              doneA, doneB;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dataIN;
  logic              ram_WR, ram_RD;
  logic [DATA_W-1:0] ram_dataOUT;

  modport slave (
    input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, ram_dataOUT,
    output gntA, gntB, doneA, doneB, rdata, busy, ram_addr, ram_dataIN, ram_WR, ram_RD
  );

  modport master (
    output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, ram_dataOUT,
    input  gntA, gntB, doneA, doneB, rdata, busy, ram_addr, ram_dataIN, ram_WR, ram_RD
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin arbiter for two clients and timed access sequencer for an
// asynchronous RAM. Each access runs SETUP (addr/data stable), STROBE (WR or RD high) and HOLD
// (addr/data held) phases; all RAM-facing and client-facing outputs are registered.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - ram_access_arbiter_if.slave (client handshakes and RAM pins)
// Optional feature: define RAM_ARB_INIT_EN to zero-fill every RAM address after reset release
// before any request is served.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_access_arbiter_if.slave   bus
);

  // Last counter value of each phase; a zero cycle count behaves as one.
  localparam logic [7:0] SetupLast  = (SETUP_CYC  == 0) ? 8'd0 : 8'(SETUP_CYC  - 1);
  localparam logic [7:0] StrobeLast = (STROBE_CYC == 0) ? 8'd0 : 8'(STROBE_CYC - 1);
  localparam logic [7:0] HoldLast   = (HOLD_CYC   == 0) ? 8'd0 : 8'(HOLD_CYC   - 1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

`ifdef RAM_ARB_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel_q, sel_d;         // owner of current transaction, 1 = B
  logic              last_b_q, last_b_d;   // B won last arbitration, so A wins the next tie
  logic              init_q, init_d;       // clear sweep in progress
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              pick_b;

  logic              gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic              done_a_q, done_a_d, done_b_q, done_b_d;
  logic              busy_q, busy_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 1'b0;
      last_b_q    <= 1'b1;
      init_q      <= InitEn;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      last_b_q    <= last_b_d;
      init_q      <= init_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Next-state logic, including capture of the winner's request fields
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    last_b_d    = last_b_q;
    init_d      = init_q;
    init_addr_d = init_addr_q;
    pick_b      = bus.reqB & (~bus.reqA | ~last_b_q);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (init_q) begin
          state_d = StSetup;
          we_d    = 1'b1;
          addr_d  = init_addr_q;
          wdata_d = '0;
        end else if (bus.reqA | bus.reqB) begin
          state_d  = StSetup;
          sel_d    = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? bus.weB    : bus.weA;
          addr_d   = pick_b ? bus.addrB  : bus.addrA;
          wdata_d  = pick_b ? bus.wdataB : bus.wdataA;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if (init_q && (init_addr_q != LastAddr)) begin
            // Sweep chains straight into the next address so busy never drops.
            state_d     = StSetup;
            init_addr_d = init_addr_q + 1'b1;
            addr_d      = init_addr_q + 1'b1;
          end else begin
            state_d = StIdle;
            init_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: decoded from next state so every output comes straight from a flop
  always_comb begin
    busy_d   = (state_d != StIdle) | init_d;
    gnt_a_d  = (state_d != StIdle) & ~init_d & ~sel_d;
    gnt_b_d  = (state_d != StIdle) & ~init_d &  sel_d;
    done_a_d = (state_d == StHold) & (cnt_d == HoldLast) & ~init_d & ~sel_d;
    done_b_d = (state_d == StHold) & (cnt_d == HoldLast) & ~init_d &  sel_d;
    wr_d     = (state_d == StStrobe) &  we_d;
    rd_d     = (state_d == StStrobe) & ~we_d;
    rdata_d  = rdata_q;
    if ((state_q == StStrobe) && (cnt_q == StrobeLast) && !we_q) begin
      rdata_d = bus.ram_dataOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gntA       = gnt_a_q;
  assign bus.gntB       = gnt_b_q;
  assign bus.doneA      = done_a_q;
  assign bus.doneB      = done_b_q;
  assign bus.busy       = busy_q;
  assign bus.rdata      = rdata_q;
  assign bus.ram_WR     = wr_q;
  assign bus.ram_RD     = rd_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_dataIN = wdata_q;

endmodule
